adsr_envelope: RTL and testbench

- Per-voice ADSR amplitude envelope generator, directly upstream of the NCO.
- Converts a note gate plus four envelope settings into a 16-bit amplitude sequence. It drives the NCO amplitude load strobe and key-on.
- Level advances once per audio sample tick.
- Gate changes are tracked every clock, so the NCO output mutes exactly when the envelope reaches idle.

---
 rtl/synth_pkg.sv | 60 ++++++
 rtl/adsr_envelope.sv | 112 +++++++++++
 tb/tb_adsr_envelope.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: types and helpers shared by envelope-style generators.
//   env_state_t : envelope state encoding (IDLE..RELEASE).
//   ENV_WIDTH   : envelope level / rate width (matches the NCO amplitude width).
//   ENV_MAX     : all-ones level at ENV_WIDTH (saturation point).
//   env_step    : one envelope step, either a saturating add (rising) or a
//                 clamp-to-floor subtract (falling), reporting when the
//                 segment has finished.
package synth_pkg;

    localparam int ENV_WIDTH = 16;
    localparam logic [ENV_WIDTH-1:0] ENV_MAX = {ENV_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    typedef struct packed {
        logic                 done;
        logic [ENV_WIDTH-1:0] level;
    } env_step_t;

    // Rising: level + rate in ENV_WIDTH+1 bits; a carry or an all-ones result
    // pins the level at ENV_MAX and ends the segment.
    // Falling: if level <= floor + rate (no wrap, ENV_WIDTH+1 bits) the level
    // lands exactly on the floor and the segment ends; otherwise subtract.
    function automatic env_step_t env_step(
        input logic [ENV_WIDTH-1:0] level,
        input logic [ENV_WIDTH-1:0] rate,
        input logic [ENV_WIDTH-1:0] floor_level,
        input logic                 rising
    );
        logic [ENV_WIDTH:0] sum;
        env_step_t          res;
        sum       = {1'b0, level} + {1'b0, rate};
        res.done  = 1'b0;
        res.level = level;
        if (rising) begin
            if (sum[ENV_WIDTH] || (sum[ENV_WIDTH-1:0] == ENV_MAX)) begin
                res.done  = 1'b1;
                res.level = ENV_MAX;
            end else begin
                res.level = sum[ENV_WIDTH-1:0];
            end
        end else begin
            sum = {1'b0, floor_level} + {1'b0, rate};
            if ({1'b0, level} <= sum) begin
                res.done  = 1'b1;
                res.level = floor_level;
            end else begin
                res.level = level - rate;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR amplitude envelope feeding the NCO.
// Ports:
//   Clk, Reset        : system clock, synchronous active-high reset.
//   sample_tick       : one-cycle strobe at the audio sample rate.
//   gate              : note held (1) / released (0).
//   attack_rate, decay_rate, sustain_level, release_rate : envelope settings,
//                       sampled on the tick cycle.
//   A_out             : current envelope level (NCO A_in).
//   loadA             : one-cycle strobe when A_out changed or was re-asserted.
//   key_on            : high whenever the envelope is not IDLE.
//   env_state         : current state encoding (env_state_t).
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int WIDTH = ENV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             sample_tick,
    input  logic             gate,
    input  logic [WIDTH-1:0] attack_rate,
    input  logic [WIDTH-1:0] decay_rate,
    input  logic [WIDTH-1:0] sustain_level,
    input  logic [WIDTH-1:0] release_rate,
    output logic [WIDTH-1:0] A_out,
    output logic             loadA,
    output logic             key_on,
    output logic [2:0]       env_state
);

    env_state_t       state_r;
    logic [WIDTH-1:0] level_r;
    logic             gate_q_r;
    logic             rise_r;
    logic             fall_r;
    logic             load_r;
    logic             key_on_r;
    env_step_t        step_s;

    // Candidate next level for the active segment (single add/compare path).
    always_comb begin
        step_s = {1'b0, level_r};
        case (state_r)
            ATTACK:  step_s = env_step(level_r, attack_rate, {WIDTH{1'b0}}, 1'b1);
            DECAY:   step_s = env_step(level_r, decay_rate, sustain_level, 1'b0);
            RELEASE: step_s = env_step(level_r, release_rate, {WIDTH{1'b0}}, 1'b0);
            default: step_s = {1'b0, level_r};
        endcase
    end

    // Envelope FSM: gate edges (registered one cycle after gate_q) take
    // priority over a same-cycle tick, and always keep the current level.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= IDLE;
            level_r  <= {WIDTH{1'b0}};
            gate_q_r <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
            load_r   <= 1'b0;
            key_on_r <= 1'b0;
        end else begin
            gate_q_r <= gate;
            rise_r   <= gate & ~gate_q_r;
            fall_r   <= ~gate & gate_q_r;
            load_r   <= 1'b0;
            if (rise_r) begin
                state_r  <= ATTACK;
                key_on_r <= 1'b1;
                load_r   <= 1'b1;
            end else if (fall_r && ((state_r == ATTACK) || (state_r == DECAY) ||
                                    (state_r == SUSTAIN))) begin
                state_r <= RELEASE;
                load_r  <= 1'b1;
            end else if (sample_tick && (state_r != IDLE)) begin
                load_r <= 1'b1;
                case (state_r)
                    ATTACK: begin
                        level_r <= step_s.level;
                        if (step_s.done) state_r <= DECAY;
                    end
                    DECAY: begin
                        level_r <= step_s.level;
                        if (step_s.done) state_r <= SUSTAIN;
                    end
                    SUSTAIN: begin
                        // Re-load every tick so live sustain changes are tracked.
                        level_r <= sustain_level;
                    end
                    RELEASE: begin
                        level_r <= step_s.level;
                        if (step_s.done) begin
                            state_r  <= IDLE;
                            key_on_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        level_r  <= {WIDTH{1'b0}};
                        key_on_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign A_out     = level_r;
    assign loadA     = load_r;
    assign key_on    = key_on_r;
    assign env_state = state_r;

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed vector table, hand-written corner sequences and
// a randomized run against an arithmetic reference model of the envelope.
module tb_adsr_envelope;

    localparam logic [2:0] S_IDLE = 3'd0, S_ATT = 3'd1, S_DEC = 3'd2,
                           S_SUS = 3'd3, S_REL = 3'd4;

    logic        Clk;
    logic        Reset;
    logic        sample_tick;
    logic        gate;
    logic [15:0] attack_rate, decay_rate, sustain_level, release_rate;
    logic [15:0] A_out;
    logic        loadA;
    logic        key_on;
    logic [2:0]  env_state;

    adsr_envelope #(.WIDTH(16)) dut (
        .Clk(Clk), .Reset(Reset), .sample_tick(sample_tick), .gate(gate),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate),
        .A_out(A_out), .loadA(loadA), .key_on(key_on), .env_state(env_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        g;
        logic [15:0] ar, dr, sl, rr;
        logic [15:0] lvl;
        logic [2:0]  st;
        logic        key;
        int          loads;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    function automatic vec_t mk(logic g, logic [15:0] ar, logic [15:0] dr,
                                logic [15:0] sl, logic [15:0] rr, logic [15:0] lvl,
                                logic [2:0] st, logic key, int loads);
        vec_t v;
        v.g = g; v.ar = ar; v.dr = dr; v.sl = sl; v.rr = rr;
        v.lvl = lvl; v.st = st; v.key = key; v.loads = loads;
        return v;
    endfunction

    function automatic logic [31:0] pk(logic [15:0] a, logic [2:0] s, logic k, logic l);
        return {11'd0, a, s, k, l};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // Reference model: state as an int, level as plain integer arithmetic,
    // gate history as the values sampled at the two previous edges.
    int m_level, m_state;
    bit m_load, m_g1, m_g2;

    task automatic model_step();
        bit rise, fall;
        int s;
        if (Reset) begin
            m_level = 0; m_state = 0; m_load = 0; m_g1 = 0; m_g2 = 0;
        end else begin
            rise = m_g1 && !m_g2;
            fall = !m_g1 && m_g2;
            m_load = 0;
            if (rise) begin
                m_state = 1; m_load = 1;
            end else if (fall && m_state >= 1 && m_state <= 3) begin
                m_state = 4; m_load = 1;
            end else if (sample_tick && m_state != 0) begin
                m_load = 1;
                case (m_state)
                    1: begin
                        s = m_level + int'(attack_rate);
                        if (s >= 65535) begin m_level = 65535; m_state = 2; end
                        else m_level = s;
                    end
                    2: begin
                        if (m_level <= int'(sustain_level) + int'(decay_rate)) begin
                            m_level = int'(sustain_level); m_state = 3;
                        end else m_level = m_level - int'(decay_rate);
                    end
                    3: m_level = int'(sustain_level);
                    default: begin
                        if (m_level <= int'(release_rate)) begin
                            m_level = 0; m_state = 0;
                        end else m_level = m_level - int'(release_rate);
                    end
                endcase
            end
            m_g2 = m_g1;
            m_g1 = gate;
        end
    endtask

    initial begin
        int loads;
        Reset = 1'b1; gate = 1'b1; sample_tick = 1'b0;
        attack_rate = 16'h4000; decay_rate = 16'h1000;
        sustain_level = 16'h8000; release_rate = 16'h2000;

        // Reset held with gate high: everything stays zero.
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("reset_hold%0d", i), pk(A_out, env_state, key_on, loadA),
                  pk(16'h0000, S_IDLE, 1'b0, 1'b0));
        end
        Reset = 1'b0;
        cyc();
        check("post_reset_edge1", pk(A_out, env_state, key_on, loadA),
              pk(16'h0000, S_IDLE, 1'b0, 1'b0));
        cyc();
        check("post_reset_attack", pk(A_out, env_state, key_on, loadA),
              pk(16'h0000, S_ATT, 1'b1, 1'b1));

        // Each row: apply gate/settings, three quiet cycles, then one tick.
        vecs[0]  = mk(1'b1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'h4000, S_ATT, 1'b1, 1);
        vecs[1]  = mk(1'b1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'h8000, S_ATT, 1'b1, 1);
        vecs[2]  = mk(1'b1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'hC000, S_ATT, 1'b1, 1);
        vecs[3]  = mk(1'b1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'hFFFF, S_DEC, 1'b1, 1);
        vecs[4]  = mk(1'b1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'hEFFF, S_DEC, 1'b1, 1);
        vecs[5]  = mk(1'b1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'hDFFF, S_DEC, 1'b1, 1);
        vecs[6]  = mk(1'b1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'hCFFF, S_DEC, 1'b1, 1);
        vecs[7]  = mk(1'b1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'hBFFF, S_DEC, 1'b1, 1);
        vecs[8]  = mk(1'b1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'hAFFF, S_DEC, 1'b1, 1);
        vecs[9]  = mk(1'b1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'h9FFF, S_DEC, 1'b1, 1);
        vecs[10] = mk(1'b1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'h8FFF, S_DEC, 1'b1, 1);
        vecs[11] = mk(1'b1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'h8000, S_SUS, 1'b1, 1);
        vecs[12] = mk(1'b1, 16'h4000, 16'h1000, 16'h6000, 16'h2000, 16'h6000, S_SUS, 1'b1, 1);
        vecs[13] = mk(1'b0, 16'h4000, 16'h1000, 16'h6000, 16'h2000, 16'h4000, S_REL, 1'b1, 2);
        vecs[14] = mk(1'b0, 16'h4000, 16'h1000, 16'h6000, 16'h2000, 16'h2000, S_REL, 1'b1, 1);
        vecs[15] = mk(1'b0, 16'h4000, 16'h1000, 16'h6000, 16'h2000, 16'h0000, S_IDLE, 1'b0, 1);
        vecs[16] = mk(1'b0, 16'h4000, 16'h1000, 16'h6000, 16'h2000, 16'h0000, S_IDLE, 1'b0, 0);
        vecs[17] = mk(1'b1, 16'h4000, 16'h1000, 16'h6000, 16'h2000, 16'h4000, S_ATT, 1'b1, 2);
        vecs[18] = mk(1'b1, 16'h2000, 16'h1000, 16'h6000, 16'h2000, 16'h6000, S_ATT, 1'b1, 1);
        vecs[19] = mk(1'b0, 16'h2000, 16'h1000, 16'h6000, 16'h3000, 16'h3000, S_REL, 1'b1, 2);
        vecs[20] = mk(1'b1, 16'h4000, 16'h1000, 16'h6000, 16'h3000, 16'h7000, S_ATT, 1'b1, 2);
        vecs[21] = mk(1'b1, 16'h0000, 16'h1000, 16'h6000, 16'h3000, 16'h7000, S_ATT, 1'b1, 1);
        vecs[22] = mk(1'b1, 16'h0000, 16'h1000, 16'h6000, 16'h3000, 16'h7000, S_ATT, 1'b1, 1);

        for (int i = 0; i < NV; i++) begin
            gate = vecs[i].g;
            attack_rate = vecs[i].ar; decay_rate = vecs[i].dr;
            sustain_level = vecs[i].sl; release_rate = vecs[i].rr;
            loads = 0;
            repeat (3) begin
                cyc();
                loads += (loadA ? 1 : 0);
            end
            sample_tick = 1'b1;
            cyc();
            sample_tick = 1'b0;
            loads += (loadA ? 1 : 0);
            check($sformatf("vec%0d level/state/key", i), pk(A_out, env_state, key_on, 1'b0),
                  pk(vecs[i].lvl, vecs[i].st, vecs[i].key, 1'b0));
            check($sformatf("vec%0d loadA count", i), loads, vecs[i].loads);
        end

        // Falling edge seen in the same cycle as a tick: transition wins.
        attack_rate = 16'h1000;
        gate = 1'b0;
        cyc();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        check("fall_with_tick", pk(A_out, env_state, key_on, loadA),
              pk(16'h7000, S_REL, 1'b1, 1'b1));

        // Rising edge seen in the same cycle as a tick: retrigger, no step.
        release_rate = 16'h1000;
        gate = 1'b1;
        cyc();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        check("rise_with_tick", pk(A_out, env_state, key_on, loadA),
              pk(16'h7000, S_ATT, 1'b1, 1'b1));

        // attack_rate 0 holds the level in ATTACK indefinitely.
        attack_rate = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            sample_tick = 1'b1;
            cyc();
            sample_tick = 1'b0;
            check($sformatf("attack_hold%0d", i), pk(A_out, env_state, key_on, loadA),
                  pk(16'h7000, S_ATT, 1'b1, 1'b1));
            cyc();
        end

        // Randomized run against the reference model.
        Reset = 1'b1;
        model_step();
        cyc();
        Reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            Reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 29) == 0) gate = ~gate;
            sample_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) begin
                attack_rate   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h3000));
                decay_rate    = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h3000));
                release_rate  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h3000));
                sustain_level = 16'($urandom_range(0, 16'hFFFF));
            end
            model_step();
            cyc();
            check($sformatf("random cycle %0d {A,state,key,load}", i),
                  pk(A_out, env_state, key_on, loadA),
                  pk(m_level[15:0], m_state[2:0], (m_state != 0), m_load));
        end
        Reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
